// File: rtl/kws_pkg.sv
// kws_pkg: shared keyword-spotting types, constants and the ceilLog2 helper
package kws_pkg;
  localparam int KEYWORD_WIDTH = 4;
  localparam logic [KEYWORD_WIDTH-1:0] SILENCE_KEYWORD = 4'd0;
  localparam int NUM_CLASSES = 16;
  typedef enum logic [1:0] {RUN, EMIT, HOLDOFF} kdf_state_t;
  // smallest r with 2**r >= x (0 for x <= 1)
  function automatic int ceilLog2(input int x);
    int r = 0;
    while ((1 << r) < x) r++;
    return r;
  endfunction
endpackage

// File: rtl/kw_history_buffer.sv
// kw_history_buffer: circular store of the last WINDOW labels
// Ports: clk; rst (async, active-low); wr_en/wr_data write the label at the
// pointer and advance it; evicted is the slot the next write will overwrite.
module kw_history_buffer import kws_pkg::*; #(
  parameter int WINDOW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [KEYWORD_WIDTH-1:0] wr_data,
  output logic [KEYWORD_WIDTH-1:0] evicted
);
  localparam int PW = ceilLog2(WINDOW);
  logic [KEYWORD_WIDTH-1:0] r_slot [WINDOW];
  logic [PW-1:0]            r_ptr;
  assign evicted = r_slot[r_ptr];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_slot <= '{default: '0};
      r_ptr  <= '0;
    end else if (wr_en) begin
      r_slot[r_ptr] <= wr_data;
      r_ptr         <= (r_ptr == PW'(WINDOW - 1)) ? '0 : r_ptr + PW'(1);
    end
endmodule

// File: rtl/keyword_decision_filter.sv
// keyword_decision_filter: supermajority vote over recent keyword labels with hold-off
// Ports: clk; rst (async, active-low); kw_valid/kw_ready/kw_in label input
// stream; det_valid/det_ready/det_keyword/det_count detection output stream.
module keyword_decision_filter import kws_pkg::*; #(
  parameter int WINDOW    = 8,
  parameter int THRESHOLD = 5,
  parameter int HOLDOFF   = 4,
  localparam int WIDTH_CNT = ceilLog2(WINDOW + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     kw_valid,
  output logic                     kw_ready,
  input  logic [KEYWORD_WIDTH-1:0] kw_in,
  output logic                     det_valid,
  input  logic                     det_ready,
  output logic [KEYWORD_WIDTH-1:0] det_keyword,
  output logic [WIDTH_CNT-1:0]     det_count
);
  if (WINDOW < 2 || WINDOW > 16 || THRESHOLD <= WINDOW / 2 || THRESHOLD > WINDOW ||
      HOLDOFF < 0 || HOLDOFF > 255) begin : g_bad_params
    $error("keyword_decision_filter: illegal WINDOW/THRESHOLD/HOLDOFF combination");
  end
  kdf_state_t               r_state, w_state_n;
  logic [WIDTH_CNT-1:0]     r_count [NUM_CLASSES];
  logic [7:0]               r_hold;
  logic                     r_det_valid;
  logic [KEYWORD_WIDTH-1:0] r_det_kw;
  logic [WIDTH_CNT-1:0]     r_det_cnt;
  logic [KEYWORD_WIDTH-1:0] w_evicted;
  logic [WIDTH_CNT-1:0]     w_new_cnt;
  logic                     w_acc, w_same, w_fire, w_ack;
  kw_history_buffer #(.WINDOW(WINDOW)) u_hist (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_acc),
    .wr_data (kw_in),
    .evicted (w_evicted)
  );
  assign w_acc     = kw_valid && kw_ready;
  assign w_same    = w_evicted == kw_in;
  // count after this accept: +1 for the incoming label unless it replaces itself
  assign w_new_cnt = r_count[kw_in] + WIDTH_CNT'(!w_same);
  assign w_ack     = r_state == EMIT && det_ready;
  assign det_valid   = r_det_valid;
  assign det_keyword = r_det_kw;
  assign det_count   = r_det_cnt;
  always_comb begin
    w_state_n = r_state;
    kw_ready  = r_state != EMIT;
    w_fire    = 1'b0;
    case (r_state)
      RUN:
        if (w_acc && kw_in != SILENCE_KEYWORD && w_new_cnt >= WIDTH_CNT'(THRESHOLD)) begin
          w_fire    = 1'b1;
          w_state_n = EMIT;
        end
      EMIT:
        if (det_ready) w_state_n = (HOLDOFF > 0) ? kws_pkg::HOLDOFF : RUN;
      kws_pkg::HOLDOFF:
        if (w_acc && r_hold == 8'd1) w_state_n = RUN;
      default: w_state_n = RUN;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state     <= RUN;
      r_hold      <= '0;
      r_det_valid <= 1'b0;
      r_det_kw    <= '0;
      r_det_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_fire) begin
        r_det_valid <= 1'b1;
        r_det_kw    <= kw_in;
        r_det_cnt   <= w_new_cnt;
      end else if (w_ack) r_det_valid <= 1'b0;
      if (w_ack) r_hold <= 8'(HOLDOFF);
      else if (w_acc && r_state == kws_pkg::HOLDOFF) r_hold <= r_hold - 8'd1;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) r_count[i] <= (i == 0) ? WIDTH_CNT'(WINDOW) : '0;
    end else if (w_acc && !w_same) begin
      r_count[kw_in]     <= r_count[kw_in] + WIDTH_CNT'(1);
      r_count[w_evicted] <= r_count[w_evicted] - WIDTH_CNT'(1);
    end
  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_cnt_bound
    a_cnt_max: assert property (@(posedge clk) disable iff (!rst) r_count[c] <= WIDTH_CNT'(WINDOW));
  end
  a_cnt_underflow: assert property (@(posedge clk) disable iff (!rst)
    (w_acc && !w_same) |-> r_count[w_evicted] != '0);
endmodule

// File: tb/tb_keyword_decision_filter.sv
// tb_keyword_decision_filter: directed self-checking bench for keyword_decision_filter
module tb_keyword_decision_filter;
  logic       clk = 1'b0, rst = 1'b0, kw_valid = 1'b0, det_ready = 1'b1;
  logic       kw_ready, det_valid;
  logic [3:0] kw_in = 4'd0, det_keyword, det_count;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  keyword_decision_filter dut (
    .clk         (clk),
    .rst         (rst),
    .kw_valid    (kw_valid),
    .kw_ready    (kw_ready),
    .kw_in       (kw_in),
    .det_valid   (det_valid),
    .det_ready   (det_ready),
    .det_keyword (det_keyword),
    .det_count   (det_count)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    kw_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
  endtask
  // present one label, wait (bounded) for kw_ready, check detection one cycle after accept
  task automatic send(input logic [3:0] l, input logic fire, input logic [3:0] ekw, input logic [3:0] ecnt);
    int n = 0;
    kw_in = l;
    kw_valid = 1'b1;
    while (!kw_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("kw_ready_at_send", 32'(kw_ready), 32'd1);
    @(posedge clk);
    #1;
    kw_valid = 1'b0;
    check("det_valid_after_accept", 32'(det_valid), 32'(fire));
    if (fire) begin
      check("det_keyword", 32'(det_keyword), 32'(ekw));
      check("det_count", 32'(det_count), 32'(ecnt));
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    // 1: reset and idle
    do_reset();
    check("reset_det_valid", 32'(det_valid), 32'd0);
    check("reset_kw_ready", 32'(kw_ready), 32'd1);
    check("reset_det_keyword", 32'(det_keyword), 32'd0);
    check("reset_det_count", 32'(det_count), 32'd0);
    check("reset_count0", 32'(dut.r_count[0]), 32'd8);
    repeat (50) begin
      @(posedge clk);
      #1;
      check("idle_det_valid", 32'(det_valid), 32'd0);
    end
    // 2: five 3s fire on the fifth
    repeat (4) send(4'd3, 1'b0, 4'd0, 4'd0);
    send(4'd3, 1'b1, 4'd3, 4'd5);
    // 4: hold-off swallows four accepts, the fifth re-fires with a full window
    repeat (4) send(4'd3, 1'b0, 4'd0, 4'd0);
    send(4'd3, 1'b1, 4'd3, 4'd8);
    // 3: back-pressure while the detection is pending
    do_reset();
    det_ready = 1'b0;
    repeat (4) send(4'd3, 1'b0, 4'd0, 4'd0);
    send(4'd3, 1'b1, 4'd3, 4'd5);
    kw_in = 4'd3;
    kw_valid = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("stall_det_valid", 32'(det_valid), 32'd1);
      check("stall_det_keyword", 32'(det_keyword), 32'd3);
      check("stall_det_count", 32'(det_count), 32'd5);
      check("stall_kw_ready", 32'(kw_ready), 32'd0);
    end
    det_ready = 1'b1;
    @(posedge clk);
    #1;
    kw_valid = 1'b0;
    check("ack_det_valid", 32'(det_valid), 32'd0);
    check("ack_kw_ready", 32'(kw_ready), 32'd1);
    // 5: no supermajority, silence never fires, then 7 wins
    do_reset();
    for (int i = 0; i < 16; i++) send((i % 2 == 1) ? 4'd7 : 4'd3, 1'b0, 4'd0, 4'd0);
    repeat (16) send(4'd0, 1'b0, 4'd0, 4'd0);
    repeat (4) send(4'd7, 1'b0, 4'd0, 4'd0);
    send(4'd3, 1'b0, 4'd0, 4'd0);
    send(4'd7, 1'b1, 4'd7, 4'd5);
    // 6: asynchronous reset during EMIT
    do_reset();
    det_ready = 1'b0;
    repeat (4) send(4'd3, 1'b0, 4'd0, 4'd0);
    send(4'd3, 1'b1, 4'd3, 4'd5);
    #2 rst = 1'b0;
    #1;
    check("async_rst_det_valid", 32'(det_valid), 32'd0);
    check("async_rst_kw_ready", 32'(kw_ready), 32'd1);
    check("async_rst_count0", 32'(dut.r_count[0]), 32'd8);
    check("async_rst_count3", 32'(dut.r_count[3]), 32'd0);
    @(negedge clk) rst = 1'b1;
    det_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) send(4'd3, 1'b0, 4'd0, 4'd0);
    send(4'd3, 1'b1, 4'd3, 4'd5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
